// File: rtl/uart_tx_buf_pkg.sv
// Shared UART definitions: default clock/baud, FSM states, and baud count.
// Imported by the transmit FIFO and the transmitter top level.
package uart_tx_buf_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BPS      = 115_200;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  function automatic int baud_count(
    input int clk_freq,
    input int bps
  );
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_tx_buf_fifo.sv
// Byte FIFO for the UART transmitter; level is its own counter.
// Ports: push/din in, pop/dout out, level/full/empty status.
module uart_tx_fifo
  import uart_tx_buf_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     push_i,
  input  logic [7:0]               din_i,
  input  logic                     pop_i,
  output logic [7:0]               dout_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [LW-1:0] level_q;
  logic          push_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign dout_o  = mem_q[rd_q];
  // A push at full is dropped even when a pop happens on the same edge.
  assign push_ok = push_i && !full_o;

  always_ff @(posedge sys_clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      unique case ({push_ok, pop_i})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a FIFO.
// Ports: sys_clk, sys_rst_n, tx valid/data/ready, txd, busy, level.
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int CLK_FREQ   = DEF_CLK_FREQ,
  parameter int BPS        = DEF_BPS,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          uart_tx_valid_i,
  input  logic [7:0]                    uart_txdata_i,
  output logic                          uart_tx_ready_o,
  output logic                          uart_txd_o,
  output logic                          uart_tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   uart_tx_level_o
);

  localparam int          COUNT     = baud_count(CLK_FREQ, BPS);
  localparam logic [15:0] BAUD_LAST = 16'(COUNT - 1);

  tx_state_t   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        busy_q;
  logic        pop;
  logic        full;
  logic        empty;
  logic        baud_last;
  logic [7:0]  head;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push_i    (uart_tx_valid_i),
    .din_i     (uart_txdata_i),
    .pop_i     (pop),
    .dout_o    (head),
    .level_o   (uart_tx_level_o),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign uart_tx_ready_o = !full;
  assign uart_txd_o      = txd_q;
  assign uart_tx_busy_o  = busy_q;
  assign baud_last       = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    txd_d   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = ST_START;
        end
      end
      ST_START: begin
        txd_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        txd_d = shift_q[0];
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next start bit when data waits.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= (state_q != ST_IDLE) || !empty;
    end
  end

endmodule
